// File: rtl/inp_lane_fifo.sv
// rtl/inp_lane_fifo.sv - multi-lane input FIFO with optional per-lane skew for systolic edge feed
// Pointers carry a wrap bit; lane k output passes through k extra stages when SKEW=1.
module inp_lane_fifo #(
  parameter int WORDLEN = 8,
  parameter int DEPTH   = 16,
  parameter int LANES   = 4,
  parameter int SKEW    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [LANES*WORDLEN-1:0] din,
  output logic                     full,
  input  logic                     rd_en,
  output logic [LANES*WORDLEN-1:0] dout,
  output logic [LANES-1:0]         dout_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err,
  output logic                     udf_err
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int VW   = LANES * WORDLEN;
  localparam logic [PTRW:0] PTR_ONE = (PTRW + 1)'(1);

  logic [VW-1:0] mem [DEPTH];
  logic [PTRW:0] wr_ptr;
  logic [PTRW:0] rd_ptr;
  logic          rd_accept;
  logic          wr_accept;
  logic [VW-1:0] s0_data;
  logic          s0_valid;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTRW-1:0] == rd_ptr[PTRW-1:0]) && (wr_ptr[PTRW] != rd_ptr[PTRW]);
  assign count = wr_ptr - rd_ptr;

  // A pop frees a slot in the same cycle, so a write into a full FIFO is legal alongside it.
  assign rd_accept = rd_en && !empty && !flush;
  assign wr_accept = wr_en && (!full || rd_accept) && !flush;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[PTRW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && !wr_accept) begin
        ovf_err <= 1'b1;
      end
      if (rd_en && !rd_accept) begin
        udf_err <= 1'b1;
      end
    end
  end

  // Lane-0 stage: data only moves on an accepted pop so idle lanes hold their last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_data  <= '0;
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= rd_accept;
      if (rd_accept) begin
        s0_data <= mem[rd_ptr[PTRW-1:0]];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int NST = (SKEW != 0) ? k : 0;

    if (NST == 0) begin : g_direct
      assign dout[k*WORDLEN +: WORDLEN] = s0_data[k*WORDLEN +: WORDLEN];
      assign dout_valid[k]              = s0_valid;
    end else begin : g_skew
      logic [WORDLEN-1:0] pd [1:NST];
      logic [NST:1]       pv;

      // Data advances only behind a valid bit, keeping the visible lane value stable between pulses.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 1; j <= NST; j++) begin
            pd[j] <= '0;
          end
          pv <= '0;
        end else if (flush) begin
          pv <= '0;
        end else begin
          pv[1] <= s0_valid;
          if (s0_valid) begin
            pd[1] <= s0_data[k*WORDLEN +: WORDLEN];
          end
          for (int j = 2; j <= NST; j++) begin
            pv[j] <= pv[j-1];
            if (pv[j-1]) begin
              pd[j] <= pd[j-1];
            end
          end
        end
      end

      assign dout[k*WORDLEN +: WORDLEN] = pd[NST];
      assign dout_valid[k]              = pv[NST];
    end
  end

endmodule
